// File: rtl/mem_wb_pipe_stage_if.sv
// MEM->WB entry channel: valid/ready handshake plus the write-back fields of one entry.
interface mem_wb_pipe_stage_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REGADDR_W = 5
);
  logic                 Valid;
  logic                 Ready;
  logic [DATA_W-1:0]    Instruction;
  logic                 MemToReg;
  logic                 RegWrite;
  logic [REGADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0]    ALUResult;
  logic [DATA_W-1:0]    DataMemory;

  modport master (
    output Valid, Instruction, MemToReg, RegWrite, WriteRegister, ALUResult, DataMemory,
    input  Ready
  );

  modport slave (
    input  Valid, Instruction, MemToReg, RegWrite, WriteRegister, ALUResult, DataMemory,
    output Ready
  );
endinterface

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready flow control, optional skid entry,
// synchronous flush and bubble values whenever the stage is empty.
module mem_wb_pipe_stage #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned REGADDR_W       = 5,
  parameter bit          SKID            = 1'b1,
  parameter bit          BUBBLE_MEMTOREG = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Flush,
  mem_wb_pipe_stage_if.slave  in_if,
  mem_wb_pipe_stage_if.master out_if,
  output logic [1:0]          Occupancy
);

  localparam int unsigned EntryW = 3 * DATA_W + REGADDR_W + 2;

  // Field order: instruction, mem_to_reg, reg_write, write_register, alu_result, data_memory.
  localparam logic [EntryW-1:0] BubbleEntry = {{DATA_W{1'b0}}, BUBBLE_MEMTOREG, 1'b0,
                                               {REGADDR_W{1'b0}}, {DATA_W{1'b0}},
                                               {DATA_W{1'b0}}};

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   head_q, head_d;
  logic [EntryW-1:0]   skid_q, skid_d;
  logic [EntryW-1:0]   in_entry;
  logic                accept;
  logic                pop;

  assign in_entry = {in_if.Instruction, in_if.MemToReg, in_if.RegWrite, in_if.WriteRegister,
                     in_if.ALUResult, in_if.DataMemory};
  assign accept   = in_if.Valid && in_if.Ready;
  assign pop      = out_if.Valid && out_if.Ready;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; with SKID=0 an accept in StOne always coincides with a pop.
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !pop) begin
            state_d = StFull;
          end else if (!accept && pop) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Entry storage; the head is forced to bubble values whenever the stage goes empty.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (Flush) begin
      head_d = BubbleEntry;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) head_d = in_entry;
        StOne: begin
          if (accept && pop) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d = in_entry;
          end else if (pop) begin
            head_d = BubbleEntry;
          end
        end
        StFull:  if (pop) head_d = skid_q;
        default: head_d = BubbleEntry;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_q <= BubbleEntry;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Outputs
  always_comb begin
    out_if.Valid = (state_q != StEmpty);
    in_if.Ready  = SKID ? (state_q != StFull) : ((state_q == StEmpty) || out_if.Ready);
    Occupancy    = state_q;
    {out_if.Instruction, out_if.MemToReg, out_if.RegWrite, out_if.WriteRegister,
     out_if.ALUResult, out_if.DataMemory} = head_q;
  end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: SKID=1 and SKID=0 instances share stimulus and are each
// checked against a small FIFO reference model, plus explicit vectors for corner cases.
module tb_mem_wb_pipe_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic        m2r;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] dmem;
  } entry_t;

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic        ordy;
    logic        fl;
    logic        rst;
    logic        ov;
    logic [31:0] alu_out;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  logic   Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic   Reset, Flush, iv_r, ordy_r;
  entry_t ent_r;
  logic [1:0] occ0, occ1;

  mem_wb_pipe_stage_if #(.DATA_W(32), .REGADDR_W(5)) in0 ();
  mem_wb_pipe_stage_if #(.DATA_W(32), .REGADDR_W(5)) out0 ();
  mem_wb_pipe_stage_if #(.DATA_W(32), .REGADDR_W(5)) in1 ();
  mem_wb_pipe_stage_if #(.DATA_W(32), .REGADDR_W(5)) out1 ();

  assign in0.Valid = iv_r;
  assign {in0.Instruction, in0.MemToReg, in0.RegWrite, in0.WriteRegister, in0.ALUResult,
          in0.DataMemory} = ent_r;
  assign out0.Ready = ordy_r;
  assign in1.Valid = iv_r;
  assign {in1.Instruction, in1.MemToReg, in1.RegWrite, in1.WriteRegister, in1.ALUResult,
          in1.DataMemory} = ent_r;
  assign out1.Ready = ordy_r;

  mem_wb_pipe_stage #(
    .DATA_W(32), .REGADDR_W(5), .SKID(1'b1), .BUBBLE_MEMTOREG(1'b1)
  ) u_dut0 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .in_if(in0), .out_if(out0), .Occupancy(occ0)
  );

  mem_wb_pipe_stage #(
    .DATA_W(32), .REGADDR_W(5), .SKID(1'b0), .BUBBLE_MEMTOREG(1'b1)
  ) u_dut1 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .in_if(in1), .out_if(out1), .Occupancy(occ1)
  );

  entry_t     act_e  [2];
  logic       act_ov [2];
  logic       act_ir [2];
  logic [1:0] act_occ[2];

  assign act_e[0]   = {out0.Instruction, out0.MemToReg, out0.RegWrite, out0.WriteRegister,
                       out0.ALUResult, out0.DataMemory};
  assign act_e[1]   = {out1.Instruction, out1.MemToReg, out1.RegWrite, out1.WriteRegister,
                       out1.ALUResult, out1.DataMemory};
  assign act_ov[0]  = out0.Valid;
  assign act_ov[1]  = out1.Valid;
  assign act_ir[0]  = in0.Ready;
  assign act_ir[1]  = in1.Ready;
  assign act_occ[0] = occ0;
  assign act_occ[1] = occ1;

  // Reference model: per-instance FIFO of accepted entries (capacity 2 or 1).
  entry_t mdl[2][2];
  int     cnt[2];
  entry_t bub;
  int     vectors = 0;
  int     miscompares = 0;
  int     ins1, outs1;

  // Snapshot of the SKID=1 instance taken at the sample point of the last step.
  logic        s_ov, s_ir;
  logic [1:0]  s_occ;
  entry_t      s_e;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] alu);
    entry_t e;
    e.instr = $urandom;
    e.m2r   = 1'($urandom_range(0, 1));
    e.rw    = 1'b1;
    e.wreg  = 5'($urandom_range(0, 31));
    e.alu   = alu;
    e.dmem  = $urandom;
    return e;
  endfunction

  function automatic vec_t v(input logic iv, input logic [31:0] alu, input logic ordy,
                             input logic fl, input logic rst, input logic ov,
                             input logic [31:0] alu_out, input logic [1:0] occ, input logic ir);
    vec_t r;
    r.iv = iv; r.alu = alu; r.ordy = ordy; r.fl = fl; r.rst = rst;
    r.ov = ov; r.alu_out = alu_out; r.occ = occ; r.ir = ir;
    return r;
  endfunction

  // Called #1 after a rising edge: drive, sample mid-cycle, check, advance model, next edge.
  task automatic step(input logic iv, input entry_t e, input logic ordy, input logic fl,
                      input logic rst);
    logic   exp_ov, exp_ir, do_pop, do_acc;
    entry_t exp_h;
    iv_r = iv; ent_r = e; ordy_r = ordy; Flush = fl; Reset = rst;
    #4;
    s_ov = act_ov[0]; s_ir = act_ir[0]; s_occ = act_occ[0]; s_e = act_e[0];
    for (int d = 0; d < 2; d++) begin
      exp_ov = (cnt[d] > 0);
      exp_ir = (d == 0) ? (cnt[d] < 2) : ((cnt[d] == 0) || ordy);
      exp_h  = exp_ov ? mdl[d][0] : bub;
      chk($sformatf("dut%0d InReady", d), 128'(act_ir[d]), 128'(exp_ir));
      chk($sformatf("dut%0d OutValid", d), 128'(act_ov[d]), 128'(exp_ov));
      chk($sformatf("dut%0d Occupancy", d), 128'(act_occ[d]), 128'(cnt[d]));
      chk($sformatf("dut%0d fields", d), 128'(act_e[d]), 128'(exp_h));
      if (d == 1) begin
        if (iv && act_ir[1]) ins1++;
        if (act_ov[1] && ordy) outs1++;
      end
      if (rst || fl) begin
        cnt[d] = 0;
      end else begin
        do_pop = exp_ov && ordy;
        do_acc = iv && exp_ir;
        if (do_pop) begin
          mdl[d][0] = mdl[d][1];
          cnt[d]--;
        end
        if (do_acc) begin
          mdl[d][cnt[d]] = e;
          cnt[d]++;
        end
      end
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    bub     = '0;
    bub.m2r = 1'b1;
    cnt[0]  = 0;
    cnt[1]  = 0;
    ins1    = 0;
    outs1   = 0;

    // Corner-case vectors for the SKID=1 instance: expected values sampled before each edge.
    tbl[0]  = v(1, 32'hA, 0, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[1]  = v(1, 32'hB, 0, 0, 0,  1, 32'hA, 2'd1, 1);
    tbl[2]  = v(1, 32'hC, 0, 0, 0,  1, 32'hA, 2'd2, 0);
    tbl[3]  = v(1, 32'hC, 0, 0, 0,  1, 32'hA, 2'd2, 0);
    tbl[4]  = v(1, 32'hC, 1, 0, 0,  1, 32'hA, 2'd2, 0);
    tbl[5]  = v(1, 32'hC, 1, 0, 0,  1, 32'hB, 2'd1, 1);
    tbl[6]  = v(0, 32'h0, 1, 0, 0,  1, 32'hC, 2'd1, 1);
    tbl[7]  = v(0, 32'h0, 0, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[8]  = v(1, 32'h1, 0, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[9]  = v(1, 32'h2, 0, 0, 0,  1, 32'h1, 2'd1, 1);
    tbl[10] = v(1, 32'hD, 0, 1, 0,  1, 32'h1, 2'd2, 0);
    tbl[11] = v(0, 32'h0, 1, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[12] = v(0, 32'h0, 1, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[13] = v(1, 32'h3, 0, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[14] = v(0, 32'h0, 0, 1, 1,  1, 32'h3, 2'd1, 1);
    tbl[15] = v(0, 32'h0, 0, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[16] = v(1, 32'h4, 0, 0, 0,  0, 32'h0, 2'd0, 1);
    tbl[17] = v(0, 32'h0, 1, 1, 0,  1, 32'h4, 2'd1, 1);
    tbl[18] = v(0, 32'h0, 0, 0, 0,  0, 32'h0, 2'd0, 1);

    iv_r = 1'b0; ordy_r = 1'b0; ent_r = '0; Flush = 1'b0; Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;

    // Reset state, first cycle after Reset drops.
    step(1'b0, mk(32'h0), 1'b0, 1'b0, 1'b0);
    chk("reset OutValid", 128'(s_ov), 128'(1'b0));
    chk("reset InReady", 128'(s_ir), 128'(1'b1));
    chk("reset Occupancy", 128'(s_occ), 128'(2'd0));
    chk("reset RegWriteOut", 128'(s_e.rw), 128'(1'b0));
    chk("reset MemToRegOut", 128'(s_e.m2r), 128'(1'b1));

    // Streaming at full throughput.
    for (int i = 0; i < 9; i++) begin
      step(i < 8, mk(32'h10 + 32'(i)), 1'b1, 1'b0, 1'b0);
      if (i > 0) begin
        chk($sformatf("stream%0d OutValid", i), 128'(s_ov), 128'(1'b1));
        chk($sformatf("stream%0d ALUResultOut", i), 128'(s_e.alu), 128'(32'h10 + 32'(i - 1)));
      end
    end

    // Stall/skid, flush and reset-with-flush vectors.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].iv, mk(tbl[i].alu), tbl[i].ordy, tbl[i].fl, tbl[i].rst);
      chk($sformatf("vec%0d OutValid", i), 128'(s_ov), 128'(tbl[i].ov));
      chk($sformatf("vec%0d ALUResultOut", i), 128'(s_e.alu), 128'(tbl[i].alu_out));
      chk($sformatf("vec%0d Occupancy", i), 128'(s_occ), 128'(tbl[i].occ));
      chk($sformatf("vec%0d InReady", i), 128'(s_ir), 128'(tbl[i].ir));
      if (!tbl[i].ov) chk($sformatf("vec%0d RegWriteOut", i), 128'(s_e.rw), 128'(1'b0));
    end

    // SKID=0 instance with OutReady toggling: 20 in, 20 out.
    ins1  = 0;
    outs1 = 0;
    for (int c = 0; c < 200 && outs1 < 20; c++) begin
      step(ins1 < 20, mk(32'h100 + 32'(ins1)), (c % 2) == 0, 1'b0, 1'b0);
    end
    chk("skid0 entries in", 128'(ins1), 128'(20));
    chk("skid0 entries out", 128'(outs1), 128'(20));

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, mk($urandom), ($urandom % 3) != 0, ($urandom % 20) == 0,
           ($urandom % 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
